// File: rtl/sma_mac_accum_if.sv
// rtl/sma_mac_accum_if.sv - product input / packet-sum output handshake bundle for sma_mac_accum
//
// Purpose: groups the valid/ready product stream and the held-result
// valid/ready channel of the MAC accumulator.
// Ports (signals):
//   in_valid, in_ready, in_prod[7:0] (signed), in_last    product stream
//   out_valid, out_ready, out_acc[ACC_W-1:0] (signed),
//   out_count[CNT_W-1:0], out_ovf                         packet result
// Modports: master (producer/consumer side), slave (accumulator side).

interface sma_mac_accum_if #(
  parameter int ACC_W     = 16,
  parameter int MAX_TERMS = 16
);
  localparam int CNT_W = $clog2(MAX_TERMS + 1);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [7:0]       in_prod;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0]        out_count;
  logic                    out_ovf;

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_ovf
  );
endinterface

// File: rtl/sma_mac_accum.sv
// rtl/sma_mac_accum.sv - signed packet accumulator for 8-bit multiplier products
//
// Purpose: sums sign-extended 8-bit products into an ACC_W-bit signed
// accumulator; a packet closes on in_last or after MAX_TERMS products and
// its sum is held on a valid/ready output until taken.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   clr    synchronous clear, drops partial packet or held result
//   bus    sma_mac_accum_if.slave (product stream in, packet result out)
// Configuration macro: SMA_ACC_SAT_EN - saturate on overflow instead of wrapping.

module sma_mac_accum #(
  parameter int ACC_W     = 16,
  parameter int MAX_TERMS = 16
) (
  input logic              clk,
  input logic              rst_n,
  input logic              clr,
  sma_mac_accum_if.slave   bus
);
  localparam int CNT_W = $clog2(MAX_TERMS + 1);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    ovf_q, ovf_d;

  logic                    in_ready;
  logic                    xfer;
  logic                    close;
  logic signed [ACC_W:0]   sum_ext;
  logic                    add_ovf;
  logic signed [ACC_W-1:0] add_res;

  assign in_ready = (state_q == ST_ACC) && !clr && rst_n;
  assign xfer     = bus.in_valid && in_ready;
  assign close    = bus.in_last || (count_q == CNT_W'(MAX_TERMS - 1));

  // One guard bit above the accumulator: the top two bits disagree exactly
  // when the true sum does not fit in ACC_W bits.
  assign sum_ext = {acc_q[ACC_W-1], acc_q} + {{(ACC_W - 7){bus.in_prod[7]}}, bus.in_prod};
  assign add_ovf = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];

`ifdef SMA_ACC_SAT_EN
  // Guard bit carries the true sign of the sum, selecting the clamp rail.
  assign add_res = !add_ovf ? sum_ext[ACC_W-1:0] :
                   sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
  assign add_res = sum_ext[ACC_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      // clr wins over out_ready: a held result is dropped, not delivered.
      state_d = ST_ACC;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (xfer) begin
            acc_d   = add_res;
            count_d = count_q + 1'b1;
            ovf_d   = ovf_q | add_ovf;
            if (close) state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_d = ST_ACC;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = ST_ACC;
      endcase
    end
  end

  // Result outputs are the accumulator registers themselves; they are
  // frozen in DONE because nothing but the handshake or clr changes them.
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_acc   = acc_q;
  assign bus.out_count = count_q;
  assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_sma_mac_accum.sv
// tb/tb_sma_mac_accum.sv - scoreboard bench for sma_mac_accum

module tb_sma_mac_accum;
  localparam int ACC_W     = 9;
  localparam int MAX_TERMS = 6;
  localparam int LIM       = 1 << (ACC_W - 1);

  typedef struct {
    int acc;
    int cnt;
    int ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;

  sma_mac_accum_if #(.ACC_W(ACC_W), .MAX_TERMS(MAX_TERMS)) bus ();

  sma_mac_accum #(.ACC_W(ACC_W), .MAX_TERMS(MAX_TERMS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  res_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int   m_acc  = 0;
  int   m_cnt  = 0;
  int   m_ovf  = 0;
  bit   m_done = 1'b0;
  bit   was_rst = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact integer sum, then the out-of-range rule.
  function automatic int fold(input int s);
    int r;
`ifdef SMA_ACC_SAT_EN
    r = (s >= LIM) ? LIM - 1 : (s < -LIM) ? -LIM : s;
`else
    r = s & (2 * LIM - 1);
    if (r >= LIM) r = r - 2 * LIM;
`endif
    return r;
  endfunction

  // Drive one cycle of inputs, check handshake outputs at the falling edge,
  // advance the reference for the coming rising edge.
  task automatic cyc(input bit v, input int p, input bit l, input bit ordy,
                     input bit c, input bit rn, output bit accepted);
    int s;
    res_t r;
    accepted = 1'b0;
    bus.in_valid  = v;
    bus.in_prod   = 8'(p);
    bus.in_last   = l;
    bus.out_ready = ordy;
    clr           = c;
    rst_n         = rn;
    @(negedge clk);
    chk("in_ready", int'(bus.in_ready), int'(!m_done && !c && rn));
    chk("out_valid", int'(bus.out_valid), int'(m_done));
    if (was_rst) begin
      chk("rst_acc", int'($signed(bus.out_acc)), 0);
      chk("rst_count", int'(bus.out_count), 0);
      chk("rst_ovf", int'(bus.out_ovf), 0);
    end
    was_rst = !rn;
    if (!rn || c) begin
      if (m_done) void'(exp_q.pop_back());
      m_done = 1'b0;
      m_acc = 0; m_cnt = 0; m_ovf = 0;
    end else if (m_done) begin
      if (ordy) m_done = 1'b0;
    end else if (v) begin
      accepted = 1'b1;
      s = m_acc + p;
      if (s >= LIM || s < -LIM) m_ovf = 1;
      m_acc = fold(s);
      m_cnt++;
      if (l || m_cnt == MAX_TERMS) begin
        r.acc = m_acc; r.cnt = m_cnt; r.ovf = m_ovf;
        exp_q.push_back(r);
        m_done = 1'b1;
        m_acc = 0; m_cnt = 0; m_ovf = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: a result is consumed on the edge after a negedge that sees
  // valid && ready with no clr/reset pending.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && clr === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got acc %0d with nothing expected", $signed(bus.out_acc));
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("out_acc", int'($signed(bus.out_acc)), e.acc);
        chk("out_count", int'(bus.out_count), e.cnt);
        chk("out_ovf", int'(bus.out_ovf), e.ovf);
      end
    end
  end

  initial begin
    bit a;
    bit v, l;
    int p;
    bus.in_valid = 0; bus.in_prod = 0; bus.in_last = 0; bus.out_ready = 0;
    clr = 0; rst_n = 0;

    repeat (2) cyc(0, 0, 0, 0, 0, 0, a);

    // basic packet 64, -56, 7 -> 15
    cyc(1, 64, 0, 1, 0, 1, a);
    cyc(1, -56, 0, 1, 0, 1, a);
    cyc(1, 7, 1, 1, 0, 1, a);
    cyc(0, 0, 0, 1, 0, 1, a);

    // positive overflow, then negative overflow
    repeat (4) cyc(1, 64, 0, 1, 0, 1, a);
    cyc(1, 64, 1, 1, 0, 1, a);
    cyc(0, 0, 0, 1, 0, 1, a);
    repeat (4) cyc(1, -56, 0, 1, 0, 1, a);
    cyc(1, -56, 1, 1, 0, 1, a);
    cyc(0, 0, 0, 1, 0, 1, a);

    // auto-close at MAX_TERMS, then backpressure with a waiting product
    for (int i = 1; i <= MAX_TERMS; i++) cyc(1, i, 0, 0, 0, 1, a);
    repeat (3) cyc(1, 9, 0, 0, 0, 1, a);
    cyc(1, 9, 0, 1, 0, 1, a);
    cyc(1, 9, 1, 1, 0, 1, a);
    cyc(0, 0, 0, 1, 0, 1, a);

    // clr mid-packet with a coincident product
    cyc(1, 10, 0, 1, 0, 1, a);
    cyc(1, 20, 0, 1, 0, 1, a);
    cyc(1, 5, 0, 1, 1, 1, a);
    cyc(1, 3, 1, 1, 0, 1, a);
    cyc(0, 0, 0, 1, 0, 1, a);

    // reset mid-packet
    cyc(1, 10, 0, 1, 0, 1, a);
    cyc(1, 20, 0, 1, 0, 1, a);
    cyc(1, 5, 0, 1, 0, 0, a);
    cyc(1, 3, 1, 1, 0, 1, a);
    cyc(0, 0, 0, 1, 0, 1, a);

    // clr while a result is held
    cyc(1, 50, 1, 0, 0, 1, a);
    cyc(0, 0, 0, 1, 1, 1, a);
    cyc(0, 0, 0, 1, 0, 1, a);

    // random traffic; an offered product is held until it is taken
    v = 0; p = 0; l = 0; a = 1;
    for (int i = 0; i < 600; i++) begin
      if (!(v && !a)) begin
        v = ($urandom % 4) != 0;
        p = ($urandom % 3 == 0) ? (($urandom % 2) ? 127 : -128) : int'($urandom_range(0, 255)) - 128;
        l = ($urandom % 5) == 0;
      end
      cyc(v, p, l, ($urandom % 3) != 0, ($urandom % 30) == 0, ($urandom % 80) != 0, a);
    end

    // drain
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && !m_done) break;
      cyc(0, 0, 0, 1, 0, 1, a);
    end
    chk("drain_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sma_mac_accum.md
# sma_mac_accum

Sequential signed accumulator that consumes the 8-bit two's-complement products of the 4x4 signed array multiplier, one per accepted transfer, and emits a packet sum. A packet is a run of products closed by `in_last` or by reaching `MAX_TERMS`. The result is held on a valid/ready output until it is taken. The block sits directly downstream of the multiplier's `p` output and turns the combinational multiplier into a dot-product / MAC datapath.

## Interface
- `ACC_W`, 16: accumulator and result width in bits, signed; legal range 9..32.
- `MAX_TERMS`, 16: maximum products per packet; legal range 1..255.
- `CNT_W`, derived = clog2(`MAX_TERMS`+1): width of the term counter.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `clr`  in  1  synchronous clear; discards the partial packet.
- `in_valid`  in  1  product valid.
- `in_ready`  out  1  block can accept a product.
- `in_prod`  in  8  signed product (multiplier `p`).
- `in_last`  in  1  marks the final product of the packet.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_acc`  out  `ACC_W`  signed packet sum.
- `out_count`  out  `CNT_W`  number of products in the packet.
- `out_ovf`  out  1  overflow occurred in this packet (sticky per packet).

## Operation
- States: `ACC` (accumulating) and `DONE` (result held).
- `in_ready` = (state==`ACC`) && !`clr` && `rst_n`.
- Input transfer occurs when `in_valid` && `in_ready` are both high. On a transfer:
  - `acc` <= `acc` + sext(`in_prod`).
  - `count` <= `count` + 1.
  - `ovf` is set if the addition overflows.
- Overflow detection: form the sum at `ACC_W`+1 bits from sign-extended operands; overflow when the top two bits differ.
- Overflow result: the stored value depends on the Configuration macro.
- Packet close: a transfer with `in_last`=1, or a transfer where `count`==`MAX_TERMS`-1, moves the block to `DONE`. `out_acc`, `out_count` and `out_ovf` reflect the sum including that product.
- `DONE`: `out_valid`=1, `in_ready`=0, outputs stable.
  - When `out_valid` && `out_ready` are both high, `acc`, `count` and `ovf` clear to 0 and the state returns to `ACC`.
- `clr` in `ACC`:
  - `acc`, `count` and `ovf` go to 0.
  - A coincident `in_valid` product is not accepted, because `in_ready` is 0.
- `clr` in `DONE`: the held result is dropped, `out_valid` falls, and the state returns to `ACC`. `clr` has priority over `out_ready`.
- `in_last` is ignored when `in_valid` is low.
- A packet always contains at least one product; there is no empty-packet output.
- Reset (`rst_n`=0 at an edge, any state including mid-packet):
  - State `ACC`; `acc`, `count` and `ovf` are 0.
  - `out_valid`=0, `out_acc`=0, `out_count`=0, `out_ovf`=0.
  - `in_ready`=0 while `rst_n` is low.
  - The partial packet is lost.

## Timing
- `out_acc`, `out_count` and `out_ovf` are registers (alias of the internal state). No combinational path from `in_prod` to any output.
- Throughput: one product per cycle in `ACC`.
- Latency: the closing product is accepted at edge k; `out_valid` is 1 from edge k through the output handshake edge.
- Output handshake at edge m: the block is back in `ACC` after edge m, with `in_ready`=1 in cycle m+1. A one-cycle bubble per packet.
- `in_ready` depends combinationally only on state, `clr` and `rst_n`; never on `in_valid`.
- Upstream must hold `in_prod`, `in_last` and `in_valid` stable until the transfer; the block does not register them ahead of the transfer.

## Configuration
- `SMA_ACC_SAT_EN` defined: on overflow, `acc` saturates.
  - Positive overflow gives 2^(`ACC_W`-1)-1.
  - Negative overflow gives -2^(`ACC_W`-1).
  - Subsequent adds continue from the saturated value; `ovf` is set.
- `SMA_ACC_SAT_EN` undefined: `acc` wraps modulo 2^`ACC_W` (low `ACC_W` bits of the sum); `ovf` is still set.
- `out_ovf` behaviour is identical in both builds.

## Test plan
- Basic packet (defaults): products 64, -56, 7 (last on 7) -> `out_acc`=15, `out_count`=3, `out_ovf`=0, `out_valid` the cycle after the third transfer.
- Overflow (`ACC_W`=9): five products of 64, last on the fifth.
  - With `SMA_ACC_SAT_EN` -> `out_acc`=255, `out_ovf`=1.
  - Without -> `out_acc`=-192, `out_ovf`=1.
  - Negative case: five products of -56 -> saturating build gives -256.
- Auto-close (`MAX_TERMS`=4): products 1, 2, 3, 4 with `in_last`=0 -> `out_valid` after the fourth transfer, `out_acc`=10, `out_count`=4; a fifth product waits (`in_ready`=0).
- Backpressure: hold `out_ready`=0 for 3 cycles in `DONE` -> `out_*` stable, `in_ready`=0. Then `out_ready`=1 -> `out_valid` drops next cycle, and the next packet starts from 0.
- Clear / reset mid-packet:
  - Accept 10, 20, then assert `clr` together with `in_valid` carrying 5 -> 5 is not accepted. A subsequent packet of 3 (last) yields 3, count 1.
  - Repeat with `rst_n`=0 instead of `clr` -> all outputs 0 after the edge.
